// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder
//   Streams one raster-order frame in, keeps WIN_H-1 lines in line buffers and
//   presents every stride-aligned WIN_H x WIN_W x IN_CH window as one flat bus.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  begins a frame (only honoured in IDLE)
//   pix_valid/pix_ready    input pixel handshake
//   pix_data               pixel, channel ch at [ch*FEAT_W +: FEAT_W]
//   win_valid/win_ready    output window handshake
//   win_data               element (r,c,ch) at [((r*WIN_W+c)*IN_CH+ch)*FEAT_W +: FEAT_W]
//   busy                   frame in progress (STREAM or DRAIN)
//   frame_done             one-cycle pulse after the final window is taken
module cnn_window_feeder #(
  parameter int FEAT_W  = 8,
  parameter int IN_CH   = 1,
  parameter int WIN_W   = 5,
  parameter int WIN_H   = 5,
  parameter int FRAME_W = 28,
  parameter int FRAME_H = 28,
  parameter int STRIDE  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [FEAT_W*IN_CH-1:0]                pix_data,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [FEAT_W*IN_CH*WIN_W*WIN_H-1:0]    win_data,
  output logic                                   busy,
  output logic                                   frame_done
);

  localparam int PIX_W = FEAT_W * IN_CH;
  localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(WIN_H - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              start_frame;
  logic              frame_done_d, frame_done_q;
  logic              win_valid_q;
  logic              pix_acc;
  logic              last_pix;
  logic              emit;
  logic              wrap;

  logic [COL_W-1:0]  col_q, col_nx;
  logic [ROW_W-1:0]  row_q, row_nx;
  // Stride phase of the current column/row relative to the first window
  // position; zero means the position is stride-aligned.
  logic [PH_W-1:0]   cph_q, rph_q;

  // Line 0 is the oldest buffered line, line WIN_H-2 the most recent.
  logic [PIX_W-1:0]  lb [WIN_H-1][FRAME_W];

  logic [WIN_H-1:0][WIN_W-1:0][PIX_W-1:0] win;
  logic [WIN_H-1:0][PIX_W-1:0]            new_col;

  function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] p);
    return (p == PH_LAST) ? '0 : p + 1'b1;
  endfunction

  assign pix_ready  = (state_q == STREAM) & (~win_valid_q | win_ready);
  assign pix_acc    = pix_valid & pix_ready;
  assign last_pix   = (row_q == ROW_LAST) & (col_q == COL_LAST);
  assign emit       = (row_q >= ROW_WIN) & (col_q >= COL_WIN) &
                      (rph_q == '0) & (cph_q == '0);
  assign busy       = (state_q != IDLE);
  assign win_valid  = win_valid_q;
  assign win_data   = win;
  assign frame_done = frame_done_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:   if (start) begin
                state_d     = STREAM;
                start_frame = 1'b1;
              end
      STREAM: if (pix_acc && last_pix) state_d = DRAIN;
      DRAIN:  if (!win_valid_q || win_ready) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
              end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- position counters ----------------
  always_comb begin
    wrap   = (col_q == COL_LAST);
    col_nx = col_q + 1'b1;
    row_nx = row_q;
    if (wrap) begin
      col_nx = '0;
      row_nx = row_q + 1'b1;
    end
  end

  // The last pixel leaves the counters parked; the next start clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      cph_q <= '0;
      rph_q <= '0;
    end else if (start_frame) begin
      col_q <= '0;
      row_q <= '0;
      cph_q <= '0;
      rph_q <= '0;
    end else if (pix_acc && !last_pix) begin
      col_q <= col_nx;
      row_q <= row_nx;
      cph_q <= (col_nx == COL_WIN) ? '0 : ph_inc(cph_q);
      if (wrap) rph_q <= (row_nx == ROW_WIN) ? '0 : ph_inc(rph_q);
    end
  end

  // ---------------- window valid ----------------
  // A new window wins over a completing handshake so back-to-back windows
  // keep valid high without a gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              win_valid_q <= 1'b0;
    else if (pix_acc && emit)  win_valid_q <= 1'b1;
    else if (win_ready)        win_valid_q <= 1'b0;
  end

  // ---------------- line buffers ----------------
  // Reads (new_col) see the pre-write contents; the write shifts each line
  // up by one at the current column.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      for (int k = 0; k < WIN_H-2; k++) lb[k][col_q] <= lb[k+1][col_q];
      lb[WIN_H-2][col_q] <= pix_data;
    end
  end

  for (genvar r = 0; r < WIN_H-1; r++) begin : g_rd
    assign new_col[r] = lb[r][col_q];
  end
  assign new_col[WIN_H-1] = pix_data;

  // ---------------- window shift register ----------------
  // Each row shifts toward c=0; the new column enters at c=WIN_W-1.
  for (genvar r = 0; r < WIN_H; r++) begin : g_row
    if (WIN_W > 1) begin : g_shift
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     win[r] <= '0;
        else if (pix_acc) win[r] <= {new_col[r], win[r][WIN_W-1:1]};
      end
    end else begin : g_single
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     win[r] <= '0;
        else if (pix_acc) win[r] <= new_col[r];
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Self-checking bench for cnn_window_feeder.
//   dut0: default parameters (IN_CH=1, STRIDE=1)
//   dut1: IN_CH=2, STRIDE=2, channel1 = channel0 ^ 8'hFF
// Expected windows come from the frame image held in px[][] by cutting out
// every stride-aligned WIN_H x WIN_W block in raster order.
module tb_cnn_window_feeder;

  localparam int FW = 28;
  localparam int FH = 28;
  localparam int WW = 5;
  localparam int WH = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic win_ready = 1'b1;
  logic [7:0] pix = '0;
  int   sel = 0;

  logic         pr0, wv0, busy0, fd0;
  logic [199:0] wd0;
  logic         pr1, wv1, busy1, fd1;
  logic [399:0] wd1;

  int checks = 0;
  int failures = 0;
  int rdy_pct = 100;
  int px [FH][FW];

  logic [399:0] q0 [$];
  logic [399:0] q1 [$];
  int nfd0 = 0;
  int nfd1 = 0;
  logic stall_prev = 1'b0;
  logic [199:0] stall_data = '0;

  always #5 clk = ~clk;

  cnn_window_feeder dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start && sel == 0),
    .pix_valid  (pix_valid && sel == 0),
    .pix_ready  (pr0),
    .pix_data   (pix),
    .win_valid  (wv0),
    .win_ready  (win_ready),
    .win_data   (wd0),
    .busy       (busy0),
    .frame_done (fd0)
  );

  cnn_window_feeder #(.IN_CH(2), .STRIDE(2)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start && sel == 1),
    .pix_valid  (pix_valid && sel == 1),
    .pix_ready  (pr1),
    .pix_data   ({pix ^ 8'hFF, pix}),
    .win_valid  (wv1),
    .win_ready  (win_ready),
    .win_data   (wd1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bail(input string tag);
    failures++;
    $display("FAIL %s timeout", tag);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    win_ready = ($urandom_range(99) < rdy_pct);
  endtask

  // element (r,c,ch) of a captured window with pixel width pw bits
  function automatic logic [7:0] el(input logic [399:0] w, input int pw,
                                    input int r, input int c, input int ch);
    return w[(r*WW+c)*pw + ch*8 +: 8];
  endfunction

  task automatic fill(input bit rnd);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        px[r][c] = rnd ? int'($urandom_range(255)) : (r*FW + c) % 256;
  endtask

  // Output side: capture accepted windows, count frame_done, check stalls.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wv0 && win_ready) q0.push_back({200'b0, wd0});
      if (wv1 && win_ready) q1.push_back(wd1);
      if (fd0) nfd0++;
      if (fd1) nfd1++;
      if (stall_prev) begin
        chk("stall_data_hold", {200'b0, wd0}, {200'b0, stall_data});
        chk("stall_valid_hold", wv0, 1);
      end
      if (wv0 && !win_ready) begin
        chk("stall_pix_ready", pr0, 0);
        stall_prev = 1'b1;
        stall_data = wd0;
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_abort();
    reset_n = 1'b0;
    #1;
    chk("abort_pix_ready", pr0, 0);
    chk("abort_win_valid", wv0, 0);
    chk("abort_win_data", {200'b0, wd0}, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_frame_done", fd0, 0);
    pix_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("abort_idle_pix_ready", pr0, 0);
    chk("abort_idle_busy", busy0, 0);
  endtask

  task automatic run_frame(input int s, input int gap, input int abort_at);
    int  budget;
    bit  acc;
    sel = s;
    q0.delete();
    q1.delete();
    nfd0 = 0;
    nfd1 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int idx = 0; idx < FW*FH; idx++) begin
      int r = idx / FW;
      int c = idx % FW;
      if (idx == abort_at) begin
        do_abort();
        return;
      end
      while (gap > 0 && $urandom_range(99) < gap) tick();
      pix_valid = 1'b1;
      pix = 8'(px[r][c]);
      if (idx == 200) start = 1'b1;   // must be ignored mid-frame
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        @(negedge clk);
        acc = (s == 0) ? pr0 : pr1;
        tick();
        start = 1'b0;
        budget++;
        if (budget > 1000) bail("pix_accept");
      end
      pix_valid = 1'b0;
      if (s == 0 && rdy_pct == 100)
        chk("emit_latency", wv0, (r >= WH-1 && c >= WW-1) ? 1 : 0);
    end
    budget = 0;
    while (((s == 0) ? busy0 : busy1) && budget < 5000) begin
      tick();
      budget++;
    end
    if (budget >= 5000) bail("drain");
    chk("done_with_busy_fall", (s == 0) ? fd0 : fd1, 1);
    tick();
  endtask

  task automatic check_frame(input int s);
    int stride = (s == 0) ? 1 : 2;
    int pw     = (s == 0) ? 8 : 16;
    int n      = 0;
    int got    = (s == 0) ? q0.size() : q1.size();
    for (int wr = 0; wr <= FH-WH; wr += stride)
      for (int wc = 0; wc <= FW-WW; wc += stride) begin
        logic [399:0] e = '0;
        for (int r = 0; r < WH; r++)
          for (int c = 0; c < WW; c++) begin
            e[(r*WW+c)*pw +: 8] = 8'(px[wr+r][wc+c]);
            if (s == 1) e[(r*WW+c)*pw + 8 +: 8] = 8'(px[wr+r][wc+c]) ^ 8'hFF;
          end
        if (n < got) chk("window_data", (s == 0) ? q0[n] : q1[n], e);
        n++;
      end
    chk("window_count", got, n);
    chk("frame_done_count", (s == 0) ? nfd0 : nfd1, 1);
  endtask

  initial begin
    rdy_pct = 100;
    repeat (3) tick();
    chk("reset_pix_ready", pr0, 0);
    chk("reset_win_valid", wv0, 0);
    chk("reset_win_data", {200'b0, wd0}, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_frame_done", fd0, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_pix_ready", pr0, 0);

    // ramp frame, free-flowing output
    fill(0);
    run_frame(0, 0, -1);
    check_frame(0);
    chk("n_windows_s1", q0.size(), 576);
    if (q0.size() == 576) begin
      chk("first_e00", el(q0[0], 8, 0, 0, 0), 0);
      chk("first_e44", el(q0[0], 8, 4, 4, 0), 116);
      chk("first_e04", el(q0[0], 8, 0, 4, 0), 4);
      chk("last_e44", el(q0[575], 8, 4, 4, 0), (27*28+27) % 256);
    end

    // random pixels, 30% ready, input bubbles
    fill(1);
    rdy_pct = 30;
    run_frame(0, 30, -1);
    check_frame(0);

    // reset mid-frame, then a clean frame
    rdy_pct = 100;
    fill(0);
    run_frame(0, 0, 300);
    fill(1);
    run_frame(0, 0, -1);
    check_frame(0);

    // back-to-back frames
    fill(1);
    run_frame(0, 0, -1);
    check_frame(0);
    fill(1);
    run_frame(0, 10, -1);
    check_frame(0);

    // two channels, stride 2
    fill(0);
    run_frame(1, 0, -1);
    check_frame(1);
    chk("n_windows_s2", q1.size(), 144);
    if (q1.size() == 144) begin
      chk("s2_second_e00", el(q1[1], 16, 0, 0, 0), 2);
      chk("s2_row2_e00", el(q1[12], 16, 0, 0, 0), 56);
      for (int r = 0; r < WH; r++)
        for (int c = 0; c < WW; c++)
          chk("ch1_xor", el(q1[0], 16, r, c, 1), el(q1[0], 16, r, c, 0) ^ 8'hFF);
    end
    fill(1);
    rdy_pct = 50;
    run_frame(1, 20, -1);
    check_frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
